// File: rtl/interleaver_addr_seq.sv
// interleaver_addr_seq: interleaver RAM address sequencer (write pass, gap, read pass).
// Define INTLV_SEQ_STALL_EN to let rd_rdy stall the read pass; otherwise rd_rdy is ignored.
module interleaver_addr_seq #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len_l,
  input  logic              rd_rdy,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] pb_offset,
  output logic              wr_vld,
  output logic              rd_vld,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, WR, GAP, RD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, len_q, len_d, pb_q, pb_d, addr_inc, tab_off;
  logic wr_q, wr_d, rd_q, rd_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic hit, last, adv;
  assign hit = len_l == ADDR_W'(12'h040) || len_l == ADDR_W'(12'h220) ||
               len_l == ADDR_W'(12'h820) || len_l == ADDR_W'(12'h00A);
  assign tab_off = len_l == ADDR_W'(12'h220) ? ADDR_W'(12'h040) :
                   len_l == ADDR_W'(12'h820) ? ADDR_W'(12'h260) : '0;
  assign addr_inc = addr_q + ADDR_W'(1);
  assign last = addr_inc == len_q;
`ifdef INTLV_SEQ_STALL_EN
  assign adv = rd_rdy;
`else
  assign adv = rd_rdy | 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    pb_d    = pb_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start && hit) begin
          state_d = WR;
          len_d   = len_l;
          pb_d    = tab_off;
          wr_d    = 1'b1;
        end else begin
          err_d = start;
        end
      end
      WR: begin
        state_d = last ? GAP : WR;
        addr_d  = last ? '0 : addr_inc;
        wr_d    = !last;
      end
      GAP: begin
        state_d = RD;
        addr_d  = '0;
        rd_d    = 1'b1;
      end
      default: begin
        // a stalled read keeps presenting the same address
        state_d = adv && last ? IDLE : RD;
        addr_d  = !adv ? addr_q : last ? '0 : addr_inc;
        rd_d    = !(adv && last);
        done_d  = adv && last;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      pb_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      pb_q    <= pb_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign addr      = addr_q;
  assign pb_offset = pb_q;
  assign wr_vld    = wr_q;
  assign rd_vld    = rd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_interleaver_addr_seq.sv
// tb_interleaver_addr_seq: random and directed stimulus against a position-counter reference model.
module tb_interleaver_addr_seq;
  localparam int AW = 12;
`ifdef INTLV_SEQ_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif
  logic clk = 1'b0, n_rst, start, rd_rdy;
  logic [AW-1:0] len_l, addr, pb_offset;
  logic wr_vld, rd_vld, busy, done, err;
  int total = 0, bad = 0;
  bit m_act, m_done, m_err;
  int m_pos, m_len, m_pb;
  interleaver_addr_seq #(.ADDR_W(AW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .len_l(len_l), .rd_rdy(rd_rdy),
    .addr(addr), .pb_offset(pb_offset), .wr_vld(wr_vld), .rd_vld(rd_vld),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int tab_off(input int l);
    return l == 'h040 ? 'h000 : l == 'h220 ? 'h040 : l == 'h820 ? 'h260 : l == 'h00A ? 'h000 : -1;
  endfunction
  // the sequence is one position walk: writes 0..len-1, gap at len, reads after it
  function automatic int e_addr();
    if (!m_act || m_pos == m_len) return 0;
    return m_pos < m_len ? m_pos : m_pos - m_len - 1;
  endfunction
  task automatic model_reset();
    m_act = 0; m_done = 0; m_err = 0; m_pos = 0; m_len = 0; m_pb = 0;
  endtask
  task automatic step();
    m_done = 0; m_err = 0;
    if (!n_rst) model_reset();
    else if (!m_act) begin
      if (start) begin
        if (tab_off(int'(len_l)) >= 0) begin
          m_act = 1; m_len = int'(len_l); m_pb = tab_off(int'(len_l)); m_pos = 0;
        end else m_err = 1;
      end
    end else if (m_pos > m_len && STALL && !rd_rdy) begin
    end else if (m_pos == 2 * m_len) begin
      m_act = 0; m_done = 1;
    end else m_pos++;
  endtask
  task automatic compare();
    chk("addr", 32'(addr), 32'(e_addr()));
    chk("wr_vld", 32'(wr_vld), 32'(m_act && m_pos < m_len));
    chk("rd_vld", 32'(rd_vld), 32'(m_act && m_pos > m_len));
    chk("busy", 32'(busy), 32'(m_act));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    chk("pb_offset", 32'(pb_offset), 32'(m_pb));
  endtask
  task automatic tick();
    @(posedge clk);
    step();
    #1 compare();
  endtask
  task automatic run_seq(input int len, input bit stall, input bit poke, input int exp_busy);
    int nb = 0, left = 3;
    start = 1; len_l = AW'(len); rd_rdy = 1;
    tick();
    start = 0;
    if (busy) nb++;
    for (int c = 0; c < 6000 && !m_done; c++) begin
      if (poke && c == 2) begin start = 1; len_l = AW'($urandom); end
      else start = 0;
      if (stall && m_act && m_pos == m_len + 5 && left > 0) begin rd_rdy = 0; left--; end
      else rd_rdy = 1;
      tick();
      if (busy) nb++;
    end
    start = 0; rd_rdy = 1;
    chk("done_seen", 32'(done), 1);
    chk("busy_cycles", 32'(nb), 32'(exp_busy));
  endtask
  initial begin
    n_rst = 0; start = 0; len_l = '0; rd_rdy = 1;
    model_reset();
    #2 compare();
    tick(); tick();
    @(negedge clk) n_rst = 1;
    tick();
    run_seq('h00A, 0, 0, 21);
    run_seq('h00A, 1, 0, STALL ? 24 : 21);
    tick();
    start = 1; len_l = 'h100;
    tick();
    start = 0;
    chk("err_pulse", 32'(err), 1);
    tick();
    run_seq('h220, 0, 0, 1089);
    run_seq('h040, 0, 1, 129);
    run_seq('h00A, 0, 0, 21);
    run_seq('h820, 0, 0, 4161);
    tick();
    for (int c = 0; c < 3000; c++) begin
      start = $urandom_range(0, 9) == 0;
      case ($urandom_range(0, 4))
        0: len_l = 'h00A;
        1: len_l = 'h040;
        2: len_l = 'h100;
        default: len_l = AW'($urandom);
      endcase
      rd_rdy = $urandom_range(0, 2) != 0;
      tick();
    end
    start = 0; rd_rdy = 1;
    for (int c = 0; c < 5000 && m_act; c++) tick();
    start = 1; len_l = 'h00A;
    tick();
    start = 0;
    for (int c = 0; c < 200 && !(m_act && m_pos == m_len + 6); c++) tick();
    chk("rd_addr5", 32'(addr), 5);
    #2 n_rst = 0;
    #1;
    model_reset();
    compare();
    @(negedge clk) n_rst = 1;
    tick();
    run_seq('h040, 0, 0, 129);
    chk("pb_after_rst", 32'(pb_offset), 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/interleaver_addr_seq.md
INTERLEAVER_ADDR_SEQ -- requirements
Module: interleaver_addr_seq

Interface
REQ-001 Parameter ADDR_W, default 12: width of length, address and offset fields.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to run one write/read sequence; sampled only in IDLE.
REQ-005 len_l  input  ADDR_W  block length in bits; sampled only with accepted start.
REQ-006 rd_rdy  input  1  downstream read-side acceptance (backpressure).
REQ-007 addr  output  ADDR_W  current RAM address (write or read phase).
REQ-008 pb_offset  output  ADDR_W  table offset of the latched PB size.
REQ-009 wr_vld  output  1  addr is a valid write address.
REQ-010 rd_vld  output  1  addr is a valid read request.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse after the final read handshake.
REQ-013 err  output  1  one-cycle pulse for an unsupported len_l.

Function
REQ-014 The size table SHALL be: 0x040->0x000 (PB16), 0x220->0x040 (PB136), 0x820->0x260 (PB520), 0x00A->0x000 (test).
- Values are zero-extended to ADDR_W.
REQ-015 States SHALL be IDLE, WR, GAP and RD; all outputs SHALL be registered.
REQ-016 In IDLE, start=1 with a table len_l (cycle T) SHALL latch len_l and pb_offset and enter WR at T+1.
- At T+1: addr=0, wr_vld=1.
REQ-017 start=1 with a non-table len_l SHALL pulse err at T+1 and remain in IDLE; pb_offset is unchanged.
REQ-018 WR SHALL last exactly len cycles, with addr 0..len-1 and wr_vld=1; there is no write backpressure.
REQ-019 After addr=len-1 in WR, the block SHALL spend one GAP cycle with wr_vld=rd_vld=0 and addr=0.
REQ-020 RD SHALL present addr 0..len-1 with rd_vld=1.
- addr advances only in cycles where rd_vld and rd_rdy are both 1; otherwise addr holds.
REQ-021 On handshake of addr=len-1, the next cycle SHALL be IDLE with done=1, rd_vld=0 and addr=0.
REQ-022 start SHALL be accepted in the done cycle; a new WR then begins the following cycle.
REQ-023 start and len_l SHALL be ignored in WR, GAP and RD; a changing len_l mid-sequence has no effect.
REQ-024 The address counter SHALL compare against the latched length at full ADDR_W width and never wrap.
REQ-025 pb_offset SHALL hold its value from start acceptance until the next accepted start.

Reset
REQ-026 Asserting n_rst at any time, including mid-sequence, SHALL immediately force IDLE.
- All outputs go to 0; latched length and pb_offset are cleared.
REQ-027 After reset release, the first accepted start SHALL behave exactly as REQ-016.

Configuration
REQ-028 Macro INTLV_SEQ_STALL_EN defined: rd_rdy SHALL gate RD address advance as in REQ-020.
REQ-029 Macro INTLV_SEQ_STALL_EN undefined: rd_rdy SHALL be ignored and treated as 1.
- RD then lasts exactly len cycles.

Verification
REQ-030 Scenario, test length: start with len_l=0x00A.
- Response: wr_vld for 10 cycles (addr 0..9), then 1 GAP cycle, then rd_vld for 10 cycles (addr 0..9), then done for 1 cycle.
- pb_offset=0x000 throughout.
REQ-031 Scenario, PB136: start with len_l=0x220.
- Response: pb_offset=0x040, 544 write cycles, 544 read cycles, busy high for 1089 cycles.
REQ-032 Scenario, stall (INTLV_SEQ_STALL_EN defined): len 0x00A, rd_rdy=0 for 3 cycles while addr=4 in RD.
- Response: addr holds at 4 for 3 cycles; done arrives 3 cycles later than in REQ-030.
REQ-033 Scenario, illegal length: start with len_l=0x100.
- Response: err=1 for one cycle, busy stays 0, no wr_vld.
REQ-034 Scenario, reset during RD: assert n_rst while addr=5.
- Response: all outputs 0 immediately; a later start with len_l=0x040 runs normally with pb_offset=0x000.
REQ-035 Scenario, restart and ignored start: start asserted in the done cycle.
- Response: back-to-back sequence begins the next cycle.
- A start pulsed during WR is ignored.
